bist_tpg_misr: RTL

BIST_TPG_MISR -- requirements
Module: bist_tpg_misr

---
 rtl/bist_tpg_misr_if.sv | 39 +++
 rtl/bist_tpg_misr.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bist_tpg_misr_if.sv
// BIST TPG/MISR bus: controller handshake inputs, CUT response, pattern/signature/verdict outputs.
// Pure wiring, no latency.
// No backpressure; the controller paces the block through i_run.
// Optional o_pat_cnt is present only when BIST_PATTERN_COUNT_EN is defined.
interface bist_tpg_misr_if #(
    parameter int WIDTH = 16
);
    logic             i_run;
    logic             i_seed_sel;
    logic             i_finish;
    logic             i_bist_end;
    logic [WIDTH-1:0] i_cut_resp;
    logic [WIDTH-1:0] o_test_vec;
    logic [WIDTH-1:0] o_signature;
    logic             o_pass;
    logic             o_fail;
    logic             o_done;
`ifdef BIST_PATTERN_COUNT_EN
    logic [15:0]      o_pat_cnt;
`endif

    // BIST block side
    modport slave (
        input  i_run, i_seed_sel, i_finish, i_bist_end, i_cut_resp,
        output o_test_vec, o_signature, o_pass, o_fail, o_done
`ifdef BIST_PATTERN_COUNT_EN
        , output o_pat_cnt
`endif
    );

    // Controller / test-bench side
    modport master (
        output i_run, i_seed_sel, i_finish, i_bist_end, i_cut_resp,
        input  o_test_vec, o_signature, o_pass, o_fail, o_done
`ifdef BIST_PATTERN_COUNT_EN
        , input o_pat_cnt
`endif
    );
endinterface

// File: rtl/bist_tpg_misr.sv
// Galois LFSR test-pattern generator plus MISR compactor with a registered pass/fail verdict.
// Steps take effect on the next edge; DONE rises on the second edge after FINISH is sampled.
// No backpressure: RUN low freezes both registers; RESULT ignores RUN/SEED_SEL/FINISH until BIST_END falls.
// Optional saturating pattern counter on o_pat_cnt when BIST_PATTERN_COUNT_EN is defined.
module bist_tpg_misr #(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
    parameter logic [WIDTH-1:0] SEED_A = 16'hACE1,
    parameter logic [WIDTH-1:0] SEED_B = 16'h1D87,
    parameter logic [WIDTH-1:0] GOLDEN = 16'h0000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    bist_tpg_misr_if.slave bus
);
    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_misr;
    logic             r_pass;
    logic             r_fail;
    logic             r_done;
    logic             r_seed_q;
    logic             r_end_q;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic [WIDTH-1:0] w_misr_nxt;
    logic             w_pass_nxt;
    logic             w_fail_nxt;
    logic             w_done_nxt;
    logic             w_advance;
    logic             w_rearm;
    logic             w_seed_rise;
    logic             w_end_fall;
    logic [WIDTH-1:0] w_lfsr_step;
    logic [WIDTH-1:0] w_misr_step;

    assign w_seed_rise = bus.i_seed_sel & ~r_seed_q;
    assign w_end_fall  = ~bus.i_bist_end & r_end_q;
    assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    assign w_misr_step = ((r_misr >> 1) ^ (r_misr[0] ? TAPS : '0)) ^ bus.i_cut_resp;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_ARMED;
        else          r_state <= w_state_nxt;
    end

    // Next state and next datapath values; FINISH outranks RUN, reseed replaces the LFSR step only
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_misr_nxt  = r_misr;
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail;
        w_done_nxt  = r_done;
        w_advance   = 1'b0;
        w_rearm     = 1'b0;
        case (r_state)
            ST_ARMED, ST_ACTIVE: begin
                if (bus.i_finish) begin
                    w_state_nxt = ST_COMPARE;
                end else if (bus.i_run) begin
                    w_advance   = 1'b1;
                    w_lfsr_nxt  = w_seed_rise ? SEED_B : w_lfsr_step;
                    w_misr_nxt  = w_misr_step;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_COMPARE: begin
                w_pass_nxt  = (r_misr == GOLDEN);
                w_fail_nxt  = (r_misr != GOLDEN);
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_RESULT;
            end
            ST_RESULT: begin
                if (w_end_fall) begin
                    w_rearm     = 1'b1;
                    w_lfsr_nxt  = SEED_A;
                    w_misr_nxt  = '0;
                    w_pass_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_ARMED;
                end
            end
            default: w_state_nxt = ST_ARMED;
        endcase
    end

    // Pattern, signature and verdict registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED_A;
            r_misr <= '0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            r_misr <= w_misr_nxt;
            r_pass <= w_pass_nxt;
            r_fail <= w_fail_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Delayed copies of SEED_SEL and BIST_END for edge detection, sampled in every state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seed_q <= 1'b0;
            r_end_q  <= 1'b0;
        end else begin
            r_seed_q <= bus.i_seed_sel;
            r_end_q  <= bus.i_bist_end;
        end
    end

`ifdef BIST_PATTERN_COUNT_EN
    logic [15:0] r_pat_cnt;

    // Count every LFSR advance (step or reseed), saturating; cleared on re-arm
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                              r_pat_cnt <= '0;
        else if (w_rearm)                          r_pat_cnt <= '0;
        else if (w_advance && r_pat_cnt != 16'hFFFF) r_pat_cnt <= r_pat_cnt + 16'd1;
    end

    assign bus.o_pat_cnt = r_pat_cnt;
`endif

    assign bus.o_test_vec  = r_lfsr;
    assign bus.o_signature = r_misr;
    assign bus.o_pass      = r_pass;
    assign bus.o_fail      = r_fail;
    assign bus.o_done      = r_done;
endmodule
